// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches and buffers returned
// words with their PCs so downstream stalls never lose a fetched instruction.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] iaddrbus,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] ibus,
  output logic        ibus_valid,
  output logic [31:0] pc_out
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0]   pc;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          not_full;
  logic          pop;
  logic          fire;

  // Head entry is presented straight from storage; empty shows a NOP bubble.
  always_comb begin
    ibus_valid = (count != '0);
    ibus       = '0;
    pc_out     = '0;
    if (ibus_valid) begin
      ibus   = instr_q[rd_ptr];
      pc_out = pc_q[rd_ptr];
    end
  end

  // A full FIFO may still fetch when the head leaves in the same cycle.
  always_comb begin
    not_full = (count < CW'(DEPTH));
    pop      = ibus_valid & ~stall;
    imem_req = ~reset & ~branch_taken & (not_full | pop);
    fire     = imem_req & imem_ack;
    iaddrbus = pc;
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      instr_q[wr_ptr] <= imem_data;
      pc_q[wr_ptr]    <= pc;
    end
  end

  // Reset beats branch, branch beats pop/fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC & WORD_MASK;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_taken) begin
      pc     <= branch_target & WORD_MASK;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({fire, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset) (count <= CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) (pop |-> (count != '0)));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: directed phases push expected consumed
// PCs; a negedge monitor pops and compares every instruction taken downstream.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, imem_ack;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] iaddrbus, imem_data, ibus, pc_out;
  logic        ibus_valid;

  logic        reset2;
  logic        imem_req2, ibus_valid2;
  logic [31:0] iaddrbus2, imem_data2, ibus2, pc_out2;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  assign imem_data  = imem_ack ? (iaddrbus | 32'hA000_0000) : 32'hDEAD_BEEF;
  assign imem_data2 = iaddrbus2 | 32'hA000_0000;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .iaddrbus(iaddrbus),
    .imem_ack(imem_ack), .imem_data(imem_data), .ibus(ibus),
    .ibus_valid(ibus_valid), .pc_out(pc_out)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset2), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_req(imem_req2), .iaddrbus(iaddrbus2),
    .imem_ack(1'b1), .imem_data(imem_data2), .ibus(ibus2),
    .ibus_valid(ibus_valid2), .pc_out(pc_out2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(first + 32'(4 * i));
  endtask

  // Monitor: every consumed head must match the next expected PC/word.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (mon_en && !reset && !branch_taken) begin
      if (ibus_valid) begin
        if (!stall) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got pc %h want none", pc_out);
          end else begin
            exp_pc = sb_q.pop_front();
            chk("sb_pc", pc_out, exp_pc);
            chk("sb_word", ibus, exp_pc | 32'hA000_0000);
          end
        end
      end else begin
        chk("bubble_ibus", ibus, 32'h0);
        chk("bubble_pc", pc_out, 32'h0);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ack = 1'b1; reset2 = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_ibus", ibus, 32'h0);
    chk("rst_valid", 32'(ibus_valid), 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_iaddr", iaddrbus, 32'h0);
    step();

    // Free run: cycles 1..8, consumed PCs 0x00..0x18
    reset = 1'b0;
    mon_en = 1'b1;
    push_run(32'h0, 7);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 4) chk("seq_addr", iaddrbus, 32'(4 * (k - 1)));
      if (k == 1) chk("seq_valid0", 32'(ibus_valid), 32'h0);
      if (k >= 2) chk("seq_valid", 32'(ibus_valid), 32'h1);
      step();
    end

    // Stall 5 cycles: FIFO fills, head holds, request drops
    stall = 1'b1;
    push_run(32'h1C, 3);
    for (int k = 9; k <= 13; k++) begin
      @(negedge clk);
      chk("stall_hold", ibus, 32'hA000_001C);
      if (k >= 10) begin
        chk("stall_req", 32'(imem_req), 32'h0);
        chk("stall_iaddr", iaddrbus, 32'h24);
      end
      step();
    end
    stall = 1'b0;
    step(); step(); step();

    // Branch with two buffered entries; low target bits dropped
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    push_run(32'h100, 2);
    @(negedge clk);
    chk("br_req", 32'(imem_req), 32'h0);
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("br_valid", 32'(ibus_valid), 32'h0);
    chk("br_iaddr", iaddrbus, 32'h100);
    step();
    @(negedge clk);
    chk("br_ibus", ibus, 32'hA000_0100);
    chk("br_pc_out", pc_out, 32'h100);
    step();
    step();

    // Redirect to 0x18, then withhold ack at pc=0x20
    branch_taken = 1'b1;
    branch_target = 32'h0000_001B;
    push_run(32'h18, 5);
    step();
    branch_taken = 1'b0;
    step();
    step();
    imem_ack = 1'b0;
    for (int k = 24; k <= 26; k++) begin
      @(negedge clk);
      chk("ack_iaddr", iaddrbus, 32'h20);
      chk("ack_req", 32'(imem_req), 32'h1);
      if (k >= 25) chk("ack_drain", 32'(ibus_valid), 32'h0);
      step();
    end
    imem_ack = 1'b1;
    @(negedge clk);
    chk("ack_fire_iaddr", iaddrbus, 32'h20);
    step();
    @(negedge clk);
    chk("ack_ibus", ibus, 32'hA000_0020);
    chk("ack_pc_out", pc_out, 32'h20);
    step();
    step();
    step();

    // Reset together with branch and stall
    reset = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h200;
    stall = 1'b1;
    @(negedge clk);
    chk("rst2_req_a", 32'(imem_req), 32'h0);
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("rst2_ibus", ibus, 32'h0);
    chk("rst2_valid", 32'(ibus_valid), 32'h0);
    chk("rst2_pc_out", pc_out, 32'h0);
    chk("rst2_iaddr", iaddrbus, 32'h0);
    chk("rst2_req_b", 32'(imem_req), 32'h0);
    step();
    reset = 1'b0;
    push_run(32'h0, 2);
    step(); step(); step();
    stall = 1'b1;
    step();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
    end

    // Second instance: PC wraps past the top of the address space
    reset2 = 1'b0;
    @(negedge clk);
    chk("wrap_a0", iaddrbus2, 32'hFFFF_FFF8);
    step();
    @(negedge clk);
    chk("wrap_a1", iaddrbus2, 32'hFFFF_FFFC);
    chk("wrap_i1", ibus2, 32'hFFFF_FFF8);
    chk("wrap_p1", pc_out2, 32'hFFFF_FFF8);
    step();
    @(negedge clk);
    chk("wrap_a2", iaddrbus2, 32'h0);
    chk("wrap_i2", ibus2, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk("wrap_a3", iaddrbus2, 32'h4);
    chk("wrap_i3", ibus2, 32'hA000_0000);
    chk("wrap_p3", pc_out2, 32'h0);
    chk("wrap_v3", 32'(ibus_valid2), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
